alu_seq_ctrl: RTL

Multi-cycle sequencer that borrows the 8-bit binary ALU (PL_ALU) to execute 16-bit ADD, SUB and CMP and an 8x8 unsigned MUL. Each operation is a sequence of single-byte ALU passes with carry propagated between them. The block sits beside the EX stage. While it owns the ALU (`alu_own` high), the pipeline muxes the sequencer's operand and control outputs onto the ALU inputs. The ALU stays purely combinational; this block drives its inputs from registered state and captures `alu_dout`/`alu_cout` at each clock edge.

---
 rtl/alu_seq_pkg.sv | 8 +
 rtl/alu_seq_ctrl_enc.sv | 19 +
 rtl/alu_seq_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op/state encodings and ALU control bit indices for the ALU sequencer
package alu_seq_pkg;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_CMP = 2'b10, OP_MUL = 2'b11} op_t;
    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MUL, S_DONE} state_t;
    localparam int ADD_OP = 0;
    localparam int CARRY_IN = 7;
    localparam int EN_COMP = 8;
endpackage

// File: rtl/alu_seq_ctrl_enc.sv
// alu_ctrl_enc: combinational encoder from sequencer state, op and carry to the 14-bit ALU control vector
module alu_ctrl_enc
    import alu_seq_pkg::*;
(
    input  state_t      state,
    input  op_t         op,
    input  logic        carry,
    output logic [13:0] ctrl
);
    logic byte_pass, sub;
    assign byte_pass = state == S_LO || state == S_HI;
    assign sub = op != OP_ADD;
    always_comb begin
        ctrl = '0;
        ctrl[ADD_OP] = byte_pass || state == S_MUL;
        ctrl[EN_COMP] = byte_pass && sub;
        ctrl[CARRY_IN] = state == S_LO ? sub : state == S_HI ? carry : 1'b0;
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle 16-bit ADD/SUB/CMP and optional 8x8 MUL (ALU_SEQ_MUL_EN) on a shared 8-bit ALU
module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_cout,
    output logic        rsp_gt,
    output logic        rsp_lt,
    output logic        rsp_eq,
    output logic        rsp_err,
    output logic        alu_own,
    output logic        alu_en,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    output logic [13:0] alu_ctrl,
    input  logic [7:0]  alu_dout,
    input  logic        alu_cout
);
    state_t state, nxt;
    op_t op;
    logic [15:0] a, b, res;
    logic c, err, lo, hi, mul, done, ok, accept, illegal;
    assign lo = state == S_LO;
    assign hi = state == S_HI;
    assign done = state == S_DONE;
    assign req_ready = state == S_IDLE;
    assign accept = req_valid && req_ready;
`ifdef ALU_SEQ_MUL_EN
    logic [2:0] cnt;
    assign mul = state == S_MUL;
    assign illegal = 1'b0;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (accept) cnt <= '0;
        else if (mul) cnt <= cnt + 3'd1;
    end
`else
    assign mul = 1'b0;
    assign illegal = req_op == OP_MUL;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: nxt = !req_valid ? S_IDLE : req_op != OP_MUL ? S_LO : illegal ? S_DONE : S_MUL;
            S_LO: nxt = S_HI;
            S_HI: nxt = S_DONE;
`ifdef ALU_SEQ_MUL_EN
            S_MUL: nxt = cnt == 3'd7 ? S_DONE : S_MUL;
`endif
            S_DONE: nxt = rsp_ready ? S_IDLE : S_DONE;
            default: nxt = S_IDLE;
        endcase
    end
    // res doubles as the shift-add product accumulator P during MUL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op <= OP_ADD;
            a <= '0;
            b <= '0;
            res <= '0;
            c <= 1'b0;
            err <= 1'b0;
        end else if (accept) begin
            op <= op_t'(req_op);
            a <= req_a;
            b <= req_b;
            res <= {8'h00, req_b[7:0]};
            c <= 1'b0;
            err <= illegal;
        end else if (lo) begin
            res[7:0] <= alu_dout;
            c <= alu_cout;
        end else if (hi) begin
            res[15:8] <= alu_dout;
            c <= alu_cout;
        end else if (mul) begin
            res <= {alu_cout, alu_dout, res[7:1]};
        end
    end
    alu_ctrl_enc u_enc (
        .state(state),
        .op   (op),
        .carry(c),
        .ctrl (alu_ctrl)
    );
    assign alu_own = lo || hi || mul;
    assign alu_en = alu_own;
    assign alu_op1 = lo ? a[7:0] : hi ? a[15:8] : mul ? res[15:8] : 8'h00;
    assign alu_op2 = lo ? b[7:0] : hi ? b[15:8] : (mul && res[0]) ? a[7:0] : 8'h00;
    assign ok = done && !err;
    assign rsp_valid = done;
    assign rsp_result = ok && op != OP_CMP ? res : 16'h0000;
    assign rsp_cout = ok && op != OP_MUL && c;
    assign rsp_eq = ok && op == OP_CMP && res == 16'h0000;
    assign rsp_gt = ok && op == OP_CMP && c && res != 16'h0000;
    assign rsp_lt = ok && op == OP_CMP && !c;
    assign rsp_err = done && err;
endmodule
